mmu_arbiter: RTL and testbench

MMU_ARBITER -- requirements
Module: mmu_arbiter

---
 rtl/mmu_arbiter.sv | 83 ++++++++
 tb/tb_mmu_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mmu_arbiter.sv
// mmu_arbiter: shares one l1mmu port between the L1I and L1D fill paths.
// D normally wins; after MAX_D_STREAK D grants with I waiting, I wins once.
module mmu_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         immu_read,
  input  logic [31:0]  immu_addr,
  output logic         immu_done,
  output logic [255:0] immu_read_data,
  input  logic         dmmu_read,
  input  logic         dmmu_write,
  input  logic [31:0]  dmmu_addr,
  input  logic [255:0] dmmu_write_data,
  output logic         dmmu_done,
  output logic [255:0] dmmu_read_data,
  output logic         mmu_read,
  output logic         mmu_write,
  output logic [31:0]  mmu_addr,
  output logic [255:0] mmu_write_data,
  input  logic         mmu_done,
  input  logic [255:0] mmu_read_data
);
  localparam logic [1:0] IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2, RECOVER = 2'd3;
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [1:0]     state_q, state_d;
  logic [SW-1:0]  d_streak_q, d_streak_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic           rd_q, rd_d, wr_q, wr_d;
  logic           idle, grant_d, grant_i;

  assign idle    = state_q == IDLE;
  assign grant_d = idle && (dmmu_read || dmmu_write) && !(immu_read && d_streak_q == STREAK_MAX);
  assign grant_i = idle && immu_read && !grant_d;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      d_streak_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_streak_q <= d_streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // RECOVER swallows one cycle so a requester still holding its line after done is not regranted
  always_comb begin
    state_d = idle ? (grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE)
            : (state_q == RECOVER) ? IDLE
            : mmu_done ? RECOVER : state_q;
    d_streak_d = (grant_i || (idle && !immu_read)) ? '0
               : (grant_d && d_streak_q != STREAK_MAX) ? d_streak_q + SW'(1)
               : d_streak_q;
    addr_d  = grant_d ? dmmu_addr : grant_i ? immu_addr : addr_q;
    wdata_d = grant_d ? dmmu_write_data : grant_i ? '0 : wdata_q;
    rd_d    = grant_i || (grant_d && !dmmu_write) || (rd_q && !mmu_done);
    wr_d    = (grant_d && dmmu_write) || (wr_q && !mmu_done);
  end

  always_comb begin
    immu_done = (state_q == SERVE_I) && mmu_done;
    dmmu_done = (state_q == SERVE_D) && mmu_done;
  end

  assign immu_read_data = mmu_read_data;
  assign dmmu_read_data = mmu_read_data;
  assign mmu_read       = rd_q;
  assign mmu_write      = wr_q;
  assign mmu_addr       = addr_q;
  assign mmu_write_data = wdata_q;
endmodule

// File: tb/tb_mmu_arbiter.sv
// tb_mmu_arbiter: directed vectors for mmu_arbiter; inputs driven and outputs
// sampled on the falling edge, l1mmu completion modelled by the bench.
module tb_mmu_arbiter;
  logic         sys_clk = 1'b0;
  logic         rst_n;
  logic         immu_read;
  logic [31:0]  immu_addr;
  logic         immu_done;
  logic [255:0] immu_read_data;
  logic         dmmu_read, dmmu_write;
  logic [31:0]  dmmu_addr;
  logic [255:0] dmmu_write_data;
  logic         dmmu_done;
  logic [255:0] dmmu_read_data;
  logic         mmu_read, mmu_write;
  logic [31:0]  mmu_addr;
  logic [255:0] mmu_write_data;
  logic         mmu_done;
  logic [255:0] mmu_read_data;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] RD_A5 = {32{8'hA5}};
  localparam logic [255:0] RD_3C = {32{8'h3C}};
  localparam logic [255:0] WD_1  = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] WD_2  = {8{32'h1234_5678}};
  localparam logic [255:0] WD_3  = {8{32'h0BAD_F00D}};

  mmu_arbiter #(.MAX_D_STREAK(4)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .immu_read(immu_read), .immu_addr(immu_addr), .immu_done(immu_done),
    .immu_read_data(immu_read_data),
    .dmmu_read(dmmu_read), .dmmu_write(dmmu_write), .dmmu_addr(dmmu_addr),
    .dmmu_write_data(dmmu_write_data), .dmmu_done(dmmu_done),
    .dmmu_read_data(dmmu_read_data),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
    .mmu_write_data(mmu_write_data), .mmu_done(mmu_done),
    .mmu_read_data(mmu_read_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for the grant to reach l1mmu, checks the request for lat cycles,
  // completes it on the last one and returns in the RECOVER cycle.
  task automatic serve(input string tag, input logic er, input logic ew,
                       input logic [31:0] ea, input logic [255:0] ewd,
                       input logic is_i, input int lat, input logic [255:0] rdata);
    int n = 0;
    while (!(mmu_read || mmu_write) && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, "_grant_timeout"}, n < 20, 1'b1);
    for (int c = 1; c <= lat; c++) begin
      check({tag, "_rd"}, mmu_read, er);
      check({tag, "_wr"}, mmu_write, ew);
      check({tag, "_addr"}, mmu_addr, ea);
      check({tag, "_wdata"}, mmu_write_data, ewd);
      if (c == lat) begin
        mmu_done = 1'b1;
        mmu_read_data = rdata;
        #1;
        check({tag, "_idone"}, immu_done, is_i);
        check({tag, "_ddone"}, dmmu_done, !is_i);
        check({tag, "_rdata"}, is_i ? immu_read_data : dmmu_read_data, rdata);
      end
      @(negedge sys_clk);
    end
    mmu_done = 1'b0;
    #1;
    check({tag, "_rd_off"}, mmu_read, 1'b0);
    check({tag, "_wr_off"}, mmu_write, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; immu_read = 1'b0; immu_addr = '0;
    dmmu_read = 1'b0; dmmu_write = 1'b0; dmmu_addr = '0; dmmu_write_data = '0;
    mmu_done = 1'b0; mmu_read_data = '0;
    repeat (2) @(negedge sys_clk);
    check("rst_rd", mmu_read, 1'b0);
    check("rst_wr", mmu_write, 1'b0);
    check("rst_idone", immu_done, 1'b0);
    check("rst_ddone", dmmu_done, 1'b0);
    check("rst_streak", dut.d_streak_q, 0);
    check("rst_addr", mmu_addr, 0);

    // Single I read, three-cycle latency
    rst_n = 1'b1; immu_read = 1'b1; immu_addr = 32'h0000_1000;
    serve("i_read", 1'b1, 1'b0, 32'h0000_1000, '0, 1'b1, 3, RD_A5);
    immu_read = 1'b0;
    mmu_done = 1'b1;
    #1;
    check("recover_idone", immu_done, 1'b0);
    check("recover_ddone", dmmu_done, 1'b0);
    mmu_done = 1'b0;

    // Both request out of reset: D write first, then I
    @(negedge sys_clk);
    rst_n = 1'b0; immu_read = 1'b1; immu_addr = 32'h0000_1000;
    dmmu_write = 1'b1; dmmu_addr = 32'h0000_2000; dmmu_write_data = WD_1;
    @(negedge sys_clk);
    rst_n = 1'b1;
    serve("sim_d", 1'b0, 1'b1, 32'h0000_2000, WD_1, 1'b0, 2, RD_3C);
    dmmu_write = 1'b0;
    serve("sim_i", 1'b1, 1'b0, 32'h0000_1000, '0, 1'b1, 1, RD_A5);
    immu_read = 1'b0;

    // D read and write together is a write
    dmmu_read = 1'b1; dmmu_write = 1'b1; dmmu_addr = 32'h0000_3000; dmmu_write_data = WD_2;
    serve("rw_d", 1'b0, 1'b1, 32'h0000_3000, WD_2, 1'b0, 1, RD_3C);
    dmmu_read = 1'b0; dmmu_write = 1'b0;
    @(negedge sys_clk);
    check("streak_clear", dut.d_streak_q, 0);

    // Starvation: four D grants while I waits, then I
    immu_read = 1'b1; immu_addr = 32'h0000_1040;
    dmmu_read = 1'b1; dmmu_addr = 32'h0000_4000; dmmu_write_data = WD_3;
    for (int k = 1; k <= 4; k++) begin
      serve("starve_d", 1'b1, 1'b0, 32'h0000_4000, WD_3, 1'b0, 1, RD_3C);
      check("starve_streak", dut.d_streak_q, k);
    end
    serve("starve_i", 1'b1, 1'b0, 32'h0000_1040, '0, 1'b1, 1, RD_A5);
    check("starve_streak_zero", dut.d_streak_q, 0);
    immu_read = 1'b0; dmmu_read = 1'b0;

    // Reset during SERVE_D with a late mmu_done
    @(negedge sys_clk);
    dmmu_read = 1'b1; dmmu_addr = 32'h0000_5000;
    n = 0;
    while (!mmu_read && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    check("rstd_grant_timeout", n < 20, 1'b1);
    rst_n = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1; dmmu_read = 1'b0; mmu_done = 1'b1;
    #1;
    check("rstd_ddone", dmmu_done, 1'b0);
    check("rstd_idone", immu_done, 1'b0);
    check("rstd_rd", mmu_read, 1'b0);
    check("rstd_wr", mmu_write, 1'b0);
    check("rstd_state", dut.state_q, 0);
    check("rstd_addr", mmu_addr, 0);
    @(negedge sys_clk);
    mmu_done = 1'b0;
    check("rstd_state_hold", dut.state_q, 0);

    // Spurious mmu_done while idle
    @(negedge sys_clk);
    mmu_done = 1'b1;
    #1;
    check("spur_idone", immu_done, 1'b0);
    check("spur_ddone", dmmu_done, 1'b0);
    @(negedge sys_clk);
    mmu_done = 1'b0;
    check("spur_state", dut.state_q, 0);
    check("spur_rd", mmu_read, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
